// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in/parallel-out register, LSB received first, with even-parity of its contents.
module serial_shift_reg
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              d,
  output logic [DATA_W-1:0] data,
  output logic              parity
);

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {d, data[DATA_W-1:1]};
    end
  end

  assign parity = ^data;

endmodule

// File: rtl/serial_frame_rx.sv
// Receives start/data/parity/stop frames from a one-bit-per-clock serial line into a
// single-entry valid/ready holding register with framing, parity and overrun pulses.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun
);

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_next;
  logic              par_bad;
  logic              par_bad_next;
  logic              shift_en;
  logic              frame_done;
  logic              frame_good;
  logic              handshake;
  logic [DATA_W-1:0] shift_data;
  logic              shift_par;

  serial_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .d        (d),
    .data     (shift_data),
    .parity   (shift_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      par_bad <= par_bad_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    par_bad_next = par_bad;
    shift_en     = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE: begin
        if (d == START_BIT) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          par_bad_next = 1'b0;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_next = '0;
          state_next   = PARITY_EN ? PARITY : STOP;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        // Shift register already holds every data bit when the parity bit is on the line.
        par_bad_next = shift_par ^ d;
        state_next   = STOP;
      end
      STOP: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_good = frame_done && (d == STOP_BIT) && !par_bad;
  assign handshake  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_done && (d != STOP_BIT);
      par_err   <= frame_done && par_bad;
      overrun   <= frame_good && out_valid && !out_ready;
      // A word consumed on the same edge a new one lands frees the slot for it.
      if (frame_good && (!out_valid || out_ready)) begin
        out_data  <= shift_data;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 = even parity bit present and checked; 0 = no parity bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port d, input, 1 bit: serial line, one bit per clk; idle level 1.
REQ-006 SHALL have port out_data, output, DATA_W bits: received word.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the word when out_valid and out_ready are both 1 at posedge clk.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse, stop bit sampled as 0.
REQ-010 SHALL have port par_err, output, 1 bit: one-cycle pulse, parity mismatch.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse, a good word was dropped because the holding register was full.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, parity bit (only if PARITY_EN=1), stop bit (1), each bit lasting exactly one clk.
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE SHALL go to DATA when d=0 is sampled, and SHALL stay in IDLE while d=1.
REQ-015 DATA SHALL shift d into a shift register for DATA_W cycles using a bit counter of width $clog2(DATA_W), then go to PARITY if PARITY_EN=1, else to STOP.
REQ-016 PARITY SHALL sample d and flag a mismatch if the XOR of the data bits and the parity bit is 1, then go to STOP.
REQ-017 STOP SHALL sample d and always return to IDLE; a new start bit SHALL be detected at the earliest on the cycle after the stop bit (back-to-back frames supported).
REQ-018 A frame SHALL be good only if the stop bit = 1 and no parity mismatch occurred.
REQ-019 On the STOP-sampling edge with a good frame: if out_valid=0, or out_valid=1 and out_ready=1 on that edge, out_data SHALL load the word and out_valid SHALL be 1 from that edge (latency: out_valid visible in the cycle after the stop bit).
REQ-020 On the STOP-sampling edge with a good frame, out_valid=1 and out_ready=0: the word SHALL be dropped, out_data SHALL be unchanged and overrun SHALL pulse for one cycle.
REQ-021 On the STOP-sampling edge, a stop bit of 0 SHALL pulse frame_err; a parity mismatch SHALL pulse par_err; both SHALL pulse if both errors occur; the word SHALL be discarded.
REQ-022 A handshake with no frame completing SHALL clear out_valid on that edge.
REQ-023 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 The error pulses SHALL be registered outputs, high for exactly one cycle.

Reset
REQ-025 rst=1 SHALL immediately force: state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, par_err=0, overrun=0.
REQ-026 Reset mid-frame SHALL abandon the partial frame without any pulse; after rst is released, the first d=0 SHALL be treated as a start bit.

Structure
REQ-027 Package serial_frame_pkg SHALL hold the state enum (IDLE, DATA, PARITY, STOP), the constants START_BIT=0 and STOP_BIT=1, and the default DATA_W.
REQ-028 One sub-module, serial_shift_reg (DATA_W-bit serial-in/parallel-out register with shift enable and running-parity output), SHALL be instantiated; the FSM and the holding register SHALL stay in serial_frame_rx.

Verification
REQ-029 Good frame: with defaults and out_ready=1, d = 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> out_data=0xA5, out_valid=1 for one cycle, starting the cycle after the stop bit; no error pulses.
REQ-030 Framing error: 0x3C with correct parity 0 and stop bit 0 -> frame_err pulses once; out_valid stays 0; the next good frame (0x5A) is received correctly.
REQ-031 Parity error: 0x01 with parity bit 0 -> par_err pulses once; out_valid stays 0.
REQ-032 Overrun: 0x11 then 0x22 back-to-back with out_ready=0 -> out_data stays 0x11 and overrun pulses on the edge that samples the second stop bit; raising out_ready then gives a handshake for 0x11 only.
REQ-033 Simultaneous events: out_ready=1 on the same edge the 0x33 stop bit is sampled while 0x11 is held -> 0x11 is consumed, out_data=0x33, out_valid remains 1, no overrun.
REQ-034 Reset mid-frame: rst pulsed, unaligned to clk, after 4 data bits -> all outputs 0 at once; a following 0xC3 frame is received correctly; the test is repeated with PARITY_EN=0 (10-bit frames).
